pool2x2_max: RTL and testbench
==============================

Name: pool2x2_max

Overview:
- 2x2, stride-2 max-pooling stage for the CNN datapath.
- Loads a (2n)x(2n) feature map streamed one 16-bit word per clock from the convolution stage into an internal buffer.
- On command, emits the n x n pooled map one word per clock, with an output index, then flags completion.

Parameters:
- n, default 4: pooled output side length. Input map is 2n x 2n (default 8x8 = 64 words); output is n x n (default 16 words).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset_n  input  1  synchronous active-low reset.
- en_reg  input  1  load enable; while high, conv_out is captured every clock.
- en_pooling  input  1  pooling enable; while high and no load is active, pooled words are produced.
- conv_out  input  16  input map word, signed two's complement, row-major order.
- pooling_out  output  16  pooled result (signed max of a 2x2 window), registered.
- addr  output  16  index k of the window currently on pooling_out (row-major, zero-extended), registered.
- done_pooling  output  1  high once the last window has been output.

Behaviour:
- Reset (reset_n=0 at a clock edge):
  - State goes to IDLE; write pointer wp=0; window counter k=0.
  - All buffer entries are cleared to 0.
  - pooling_out=0, addr=0, done_pooling=0.
  - Reset overrides everything, including a reset asserted mid-load or mid-pooling.
- Buffer: (2n)^2 entries x 16 bits. Entry index = row*2n + col.
- States: IDLE, POOL, DONE.
- Load, in IDLE with en_reg=1:
  - Each edge writes conv_out to buf[wp], then wp increments.
  - Once wp reaches (2n)^2, further words are ignored; wp saturates.
  - en_reg has priority over en_pooling when both are high.
  - en_reg is ignored in POOL and DONE.
- Start pooling: in IDLE with en_reg=0 and en_pooling=1, the edge outputs window k=0 and the state goes to POOL.
- Each pooling edge, for window k with r=k/n and c=k%n:
  - pooling_out <= signed max of buf[2r][2c], buf[2r][2c+1], buf[2r+1][2c], buf[2r+1][2c+1].
  - addr <= k, then k increments.
  - Ties: any equal value gives the same result.
- Latency and throughput:
  - Window k appears on the outputs after the (k+1)-th edge at which en_pooling is sampled high.
  - One word per clock; n*n edges in total.
- en_pooling dropped during POOL: the outputs hold and k freezes; production resumes when en_pooling returns high.
- Last window (k = n*n-1):
  - On the same edge that outputs it, done_pooling <= 1 and the state goes to DONE.
  - In DONE, pooling_out, addr and done_pooling hold their values.
- Leaving DONE: when en_pooling is sampled low, the state goes to IDLE, done_pooling <= 0, wp <= 0, k <= 0.
  - Buffer contents are retained; the next load overwrites them.
  - pooling_out and addr hold their last values.
- Pooling a partially loaded map uses whatever the buffer currently holds (0 or the previous frame).
- Arithmetic: signed 16-bit comparisons; no saturation or rounding needed.

Test Plan:
- Reset check: hold reset_n=0 for 2 edges -> pooling_out=0, addr=0, done_pooling=0; outputs stay 0 while en_reg=en_pooling=0.
- Ramp frame, n=4:
  - Load conv_out = 0..63 over 64 edges, then en_reg=0, en_pooling=1.
  - Required sequence, one word per edge: addr=k, pooling_out = 16*(k/4) + 2*(k%4) + 9 (k=0->9, 1->11, 3->15, 4->25, 15->63).
  - done_pooling rises together with addr=15, then holds.
- Signed data: load a frame where each window holds {-5, -1, -300, -2} -> every output is -1 (0xFFFF); a window {-1, 0x7FFF, 0, -32768} -> 0x7FFF.
- Stall and priority:
  - Drop en_pooling for 3 cycles mid-stream -> addr and pooling_out hold, then continue without skipping or repeating.
  - en_reg and en_pooling both high in IDLE -> the word is loaded and no pooling output is produced.
- Re-run:
  - After DONE, drop en_pooling -> done_pooling=0.
  - Load a new frame (63..0 descending), then pool -> k=0 gives 63, k=15 gives 9.
  - Assert reset_n=0 mid-pooling -> all outputs 0 on the next edge.

Source files
------------

// File: rtl/pool2x2_max_if.sv
// ----------------------------------------------------------------------------
// pool2x2_max_if
// Purpose : groups the load/pool handshake and data bus of the 2x2 max-pooling
//           stage so producer and pooling stage connect through one port.
// Signals :
//   en_reg       producer -> pool  load enable (capture conv_out every clock)
//   en_pooling   producer -> pool  pooling enable
//   conv_out     producer -> pool  16-bit signed input map word, row-major
//   pooling_out  pool -> consumer  16-bit signed pooled word (registered)
//   addr         pool -> consumer  window index of pooling_out (registered)
//   done_pooling pool -> consumer  high once the last window has been output
// Modports: master = side driving the enables/data, slave = pooling stage.
// ----------------------------------------------------------------------------
interface pool2x2_max_if;
    logic        en_reg;
    logic        en_pooling;
    logic [15:0] conv_out;
    logic [15:0] pooling_out;
    logic [15:0] addr;
    logic        done_pooling;

    modport master (
        output en_reg,
        output en_pooling,
        output conv_out,
        input  pooling_out,
        input  addr,
        input  done_pooling
    );

    modport slave (
        input  en_reg,
        input  en_pooling,
        input  conv_out,
        output pooling_out,
        output addr,
        output done_pooling
    );
endinterface

// File: rtl/pool2x2_max.sv
// ----------------------------------------------------------------------------
// pool2x2_max
// Purpose : 2x2 stride-2 max-pooling stage. Buffers a (2N)x(2N) map of signed
//           16-bit words streamed in row-major order, then on command emits
//           the N x N pooled map one word per clock with its window index and
//           raises a completion flag after the last window.
// Ports   :
//   clk      system clock, all state changes on the rising edge
//   reset_n  synchronous active-low reset (clears state, buffer and outputs)
//   bus      pool2x2_max_if.slave: en_reg, en_pooling, conv_out in;
//            pooling_out, addr, done_pooling out (all outputs registered)
// ----------------------------------------------------------------------------
module pool2x2_max #(
    parameter int N = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    pool2x2_max_if.slave       bus
);

    localparam int DEPTH = 4 * N * N;              // (2N)^2 buffer entries
    localparam int IW    = $clog2(DEPTH);          // buffer index width
    localparam int WPW   = $clog2(DEPTH + 1);      // write pointer must reach DEPTH
    localparam int KW    = $clog2(N * N + 1);      // window counter width

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_POOL = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [WPW-1:0]   r_wp;
    logic [KW-1:0]    r_k;
    logic [15:0]      r_buf [DEPTH];
    logic [15:0]      r_pooling_out;
    logic [15:0]      r_addr;
    logic             r_done;

    logic             w_last;
    logic             w_load;
    logic             w_pool_step;
    logic             w_leave_done;
    logic [31:0]      w_row;
    logic [31:0]      w_col;
    logic [31:0]      w_base;
    logic [IW-1:0]    w_i00;
    logic [IW-1:0]    w_i01;
    logic [IW-1:0]    w_i10;
    logic [IW-1:0]    w_i11;
    logic [15:0]      w_win_max;

    // Signed maximum of two 16-bit words; on a tie either operand is correct.
    function automatic logic [15:0] smax16(input logic [15:0] a, input logic [15:0] b);
        return ($signed(a) > $signed(b)) ? a : b;
    endfunction

    assign w_last = (r_k == KW'(N * N - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: loading has priority over pooling in IDLE.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus.en_reg) begin
                    w_next_state = ST_IDLE;
                end else if (bus.en_pooling) begin
                    w_next_state = w_last ? ST_DONE : ST_POOL;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_POOL: begin
                if (bus.en_pooling) begin
                    w_next_state = w_last ? ST_DONE : ST_POOL;
                end else begin
                    w_next_state = ST_POOL;
                end
            end
            ST_DONE: begin
                if (!bus.en_pooling) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = ST_DONE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Control strobes decoded from the current state and enables.
    always_comb begin
        w_load       = 1'b0;
        w_pool_step  = 1'b0;
        w_leave_done = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // Words past the end of the buffer are dropped; wp saturates.
                w_load      = bus.en_reg && (r_wp < WPW'(DEPTH));
                w_pool_step = !bus.en_reg && bus.en_pooling;
            end
            ST_POOL: begin
                w_pool_step = bus.en_pooling;
            end
            ST_DONE: begin
                w_leave_done = !bus.en_pooling;
            end
            default: begin
                w_load       = 1'b0;
                w_pool_step  = 1'b0;
                w_leave_done = 1'b0;
            end
        endcase
    end

    // Buffer indices of the four words in window k (row r = k/N, col c = k%N).
    always_comb begin
        w_row  = 32'(r_k) / 32'(N);
        w_col  = 32'(r_k) % 32'(N);
        w_base = w_row * 32'(4 * N) + w_col * 32'd2;
        w_i00  = IW'(w_base);
        w_i01  = IW'(w_base + 32'd1);
        w_i10  = IW'(w_base + 32'(2 * N));
        w_i11  = IW'(w_base + 32'(2 * N) + 32'd1);
    end

    assign w_win_max = smax16(smax16(r_buf[w_i00], r_buf[w_i01]),
                              smax16(r_buf[w_i10], r_buf[w_i11]));

    // Datapath: buffer writes, window counter and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wp          <= '0;
            r_k           <= '0;
            r_pooling_out <= 16'h0000;
            r_addr        <= 16'h0000;
            r_done        <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_buf[i] <= 16'h0000;
            end
        end else begin
            if (w_load) begin
                r_buf[r_wp[IW-1:0]] <= bus.conv_out;
                r_wp                <= r_wp + WPW'(1);
            end
            if (w_pool_step) begin
                r_pooling_out <= w_win_max;
                r_addr        <= 16'(r_k);
                r_k           <= r_k + KW'(1);
                if (w_last) begin
                    r_done <= 1'b1;
                end
            end
            // Buffer contents and last outputs survive; only the pointers rewind.
            if (w_leave_done) begin
                r_done <= 1'b0;
                r_wp   <= '0;
                r_k    <= '0;
            end
        end
    end

    assign bus.pooling_out  = r_pooling_out;
    assign bus.addr         = r_addr;
    assign bus.done_pooling = r_done;

endmodule

// File: tb/tb_pool2x2_max.sv
// ----------------------------------------------------------------------------
// tb_pool2x2_max
// Directed testbench for pool2x2_max (N=4): reset, ramp frame with a stall,
// load/pool priority, descending re-run with an overflow word, signed frame,
// and reset in the middle of pooling.
// ----------------------------------------------------------------------------
module tb_pool2x2_max;

    logic clk = 1'b0;
    logic reset_n;
    int   n_err = 0;
    int   n_chk = 0;

    pool2x2_max_if bus();

    pool2x2_max #(.N(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // 100 MHz-style free-running clock.
    always #5 clk = ~clk;

    // Advance one rising edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Count one comparison and report it if it does not match.
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Check all three outputs at once.
    task automatic chk_out(input string tag, input logic [15:0] e_pool,
                           input logic [15:0] e_addr, input logic e_done);
        chk({tag, ".pool"}, 32'(bus.pooling_out), 32'(e_pool));
        chk({tag, ".addr"}, 32'(bus.addr), 32'(e_addr));
        chk({tag, ".done"}, 32'(bus.done_pooling), 32'(e_done));
    endtask

    // Signed test value for window position p (0..3) of window w.
    function automatic logic [15:0] sig_val(input int w, input int p);
        logic [15:0] v;
        if (w == 5) begin
            case (p)
                0:       v = 16'hFFFF;   // -1
                1:       v = 16'h7FFF;
                2:       v = 16'h0000;
                default: v = 16'h8000;   // -32768
            endcase
        end else begin
            case (p)
                0:       v = 16'hFFFB;   // -5
                1:       v = 16'hFFFF;   // -1
                2:       v = 16'hFED4;   // -300
                default: v = 16'hFFFE;   // -2
            endcase
        end
        return v;
    endfunction

    initial begin
        logic [15:0] e;
        reset_n        = 1'b0;
        bus.en_reg     = 1'b0;
        bus.en_pooling = 1'b0;
        bus.conv_out   = 16'h0000;

        // Reset held for two edges.
        tick();
        tick();
        chk_out("reset", 16'h0000, 16'h0000, 1'b0);
        reset_n = 1'b1;
        tick();
        tick();
        chk_out("idle", 16'h0000, 16'h0000, 1'b0);

        // Ramp frame 0..63.
        bus.en_reg = 1'b1;
        for (int i = 0; i < 64; i++) begin
            bus.conv_out = 16'(i);
            tick();
        end
        bus.en_reg     = 1'b0;
        bus.en_pooling = 1'b1;
        for (int k = 0; k < 16; k++) begin
            tick();
            e = 16'(16 * (k / 4) + 2 * (k % 4) + 9);
            chk_out($sformatf("ramp_k%0d", k), e, 16'(k), (k == 15));
            if (k == 5) begin
                bus.en_pooling = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    tick();
                    chk_out($sformatf("stall%0d", s), e, 16'd5, 1'b0);
                end
                bus.en_pooling = 1'b1;
            end
        end
        tick();
        tick();
        chk_out("done_hold", 16'd63, 16'd15, 1'b1);
        bus.en_pooling = 1'b0;
        tick();
        chk_out("leave_done", 16'd63, 16'd15, 1'b0);

        // Both enables high in IDLE: loads word 0, no pooling output.
        bus.en_reg     = 1'b1;
        bus.en_pooling = 1'b1;
        bus.conv_out   = 16'd63;
        tick();
        chk_out("priority", 16'd63, 16'd15, 1'b0);
        bus.en_pooling = 1'b0;
        for (int i = 1; i < 64; i++) begin
            bus.conv_out = 16'(63 - i);
            tick();
        end
        // One word beyond a full buffer must be ignored.
        bus.conv_out = 16'h1234;
        tick();
        bus.en_reg     = 1'b0;
        bus.en_pooling = 1'b1;
        for (int k = 0; k < 16; k++) begin
            tick();
            e = 16'(63 - 16 * (k / 4) - 2 * (k % 4));
            chk_out($sformatf("desc_k%0d", k), e, 16'(k), (k == 15));
        end
        bus.en_pooling = 1'b0;
        tick();
        chk("desc_leave.done", 32'(bus.done_pooling), 32'd0);

        // Signed frame; window 5 holds the extreme values.
        bus.en_reg = 1'b1;
        for (int i = 0; i < 64; i++) begin
            bus.conv_out = sig_val(((i / 8) / 2) * 4 + (i % 8) / 2,
                                   ((i / 8) % 2) * 2 + (i % 8) % 2);
            tick();
        end
        bus.en_reg     = 1'b0;
        bus.en_pooling = 1'b1;
        for (int k = 0; k < 9; k++) begin
            tick();
            e = (k == 5) ? 16'h7FFF : 16'hFFFF;
            chk_out($sformatf("signed_k%0d", k), e, 16'(k), 1'b0);
        end

        // Reset mid-pooling clears outputs and buffer.
        reset_n = 1'b0;
        tick();
        chk_out("mid_reset", 16'h0000, 16'h0000, 1'b0);
        reset_n = 1'b1;
        tick();
        tick();
        chk_out("post_reset_pool", 16'h0000, 16'h0001, 1'b0);
        bus.en_pooling = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
